// File: rtl/rdl_reg_arbiter.sv
// Round-robin arbiter sharing one register-block access port between NREQ requesters.
// Optional requester lock (exclusive grant) is enabled with `define RDL_REG_ARB_LOCK_EN.
module rdl_reg_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 6,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
`ifdef RDL_REG_ARB_LOCK_EN
  input  logic [NREQ-1:0]      req_lock,
`endif
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 reg_we,
  output logic                 reg_re,
  output logic [AW-1:0]        reg_waddr,
  output logic [AW-1:0]        reg_raddr,
  output logic [DW-1:0]        reg_wdata,
  input  logic [DW-1:0]        reg_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  arb_state_e       state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    own;
  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  gnt_oh;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_any;
  logic [IW:0]      scan;
  logic [IW-1:0]    rr_next;
  logic             sel_wr;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;
  logic             sel_lock;

`ifdef RDL_REG_ARB_LOCK_EN
  logic             lock_act;
  logic [IW-1:0]    lock_own;

  // While locked only the lock owner may be granted.
  assign elig     = lock_act ? (req_valid & (NREQ'(1) << lock_own)) : req_valid;
  assign sel_lock = req_lock[gnt_idx];
`else
  assign elig     = req_valid;
  assign sel_lock = 1'b0;
`endif

  // First eligible requester at or after rr_ptr, wrapping at NREQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr_ptr} + (IW+1)'(k);
      if (scan >= (IW+1)'(NREQ)) scan = scan - (IW+1)'(NREQ);
      if (!gnt_any && elig[scan[IW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = scan[IW-1:0];
      end
    end
    gnt_oh = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
  end

  assign rr_next  = (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
  assign sel_wr   = req_write[gnt_idx];
  assign sel_addr = req_addr[gnt_idx*AW +: AW];
  assign sel_data = req_wdata[gnt_idx*DW +: DW];

  assign req_ready = (rst && state == ARB_IDLE) ? gnt_oh : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      own       <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      reg_waddr <= '0;
      reg_raddr <= '0;
      reg_wdata <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
`ifdef RDL_REG_ARB_LOCK_EN
      lock_act  <= 1'b0;
      lock_own  <= '0;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (gnt_any) begin
            own <= gnt_idx;
            if (sel_wr) begin
              reg_we    <= 1'b1;
              reg_waddr <= sel_addr;
              reg_wdata <= sel_data;
            end else begin
              reg_re    <= 1'b1;
              reg_raddr <= sel_addr;
            end
`ifdef RDL_REG_ARB_LOCK_EN
            // A locked accept pins arbitration to this requester; the unlocking one resumes RR.
            if (sel_lock) begin
              lock_act <= 1'b1;
              lock_own <= gnt_idx;
            end else begin
              lock_act <= 1'b0;
              rr_ptr   <= rr_next;
            end
`else
            if (!sel_lock) rr_ptr <= rr_next;
`endif
            state <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          reg_we    <= 1'b0;
          reg_re    <= 1'b0;
          rsp_rdata <= reg_re ? reg_rdata : '0;
          rsp_valid <= NREQ'(1) << own;
          state     <= ARB_RESP;
        end
        ARB_RESP: begin
          if (rsp_ready[own]) begin
            rsp_valid <= '0;
            state     <= ARB_IDLE;
          end
        end
        default: begin
          reg_we    <= 1'b0;
          reg_re    <= 1'b0;
          rsp_valid <= '0;
          state     <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rdl_reg_arbiter.sv
// Directed + randomized bench for rdl_reg_arbiter, checked against a transaction-level model.
module tb_rdl_reg_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 6;
  localparam int DW   = 8;
`ifdef RDL_REG_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NREQ-1:0]     req_valid, req_write, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_wdata;
  logic [DW-1:0]       rsp_rdata, reg_wdata, reg_rdata;
  logic                reg_we, reg_re;
  logic [AW-1:0]       reg_waddr, reg_raddr;
`ifdef RDL_REG_ARB_LOCK_EN
  logic [NREQ-1:0]     req_lock;
`endif

  rdl_reg_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef RDL_REG_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_waddr(reg_waddr), .reg_raddr(reg_raddr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  // Register block: written by the DUT strobes, or preloaded by the bench.
  logic [DW-1:0] regmem [2**AW];
  logic          pre_we;
  logic [AW-1:0] pre_a;
  logic [DW-1:0] pre_d;
  always @(posedge clk) begin
    if (reg_we) regmem[reg_waddr] <= reg_wdata;
    else if (pre_we) regmem[pre_a] <= pre_d;
  end
  assign reg_rdata = reg_re ? regmem[reg_raddr] : '0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: expected register contents plus arbitration pointer/lock.
  logic [DW-1:0] shadow [2**AW];
  int            m_rr, m_lk_own;
  bit            m_lk;
  logic          t_wr   [NREQ];
  logic          t_lock [NREQ];
  logic [AW-1:0] t_addr [NREQ];
  logic [DW-1:0] t_data [NREQ];

  int checks = 0, failures = 0;
  int obs_w, acc_cyc, acc_prev;
  int exp_lock [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    return (i < 0) ? '0 : (NREQ'(1) << i);
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v);
    logic [NREQ-1:0] e;
    e = (LOCK_EN && m_lk) ? (v & onehot(m_lk_own)) : v;
    for (int k = 0; k < NREQ; k++)
      if (((e >> ((m_rr + k) % NREQ)) & NREQ'(1)) != 0) return (m_rr + k) % NREQ;
    return -1;
  endfunction

  function automatic int decode(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (((v >> i) & NREQ'(1)) != 0) return i;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic lk);
    t_wr[i] = wr; t_addr[i] = a; t_data[i] = d; t_lock[i] = lk;
  endtask

  task automatic pack_req();
    for (int i = 0; i < NREQ; i++) begin
      req_write[i]            = t_wr[i];
      req_addr[i*AW +: AW]    = t_addr[i];
      req_wdata[i*DW +: DW]   = t_data[i];
`ifdef RDL_REG_ARB_LOCK_EN
      req_lock[i]             = t_lock[i];
`endif
    end
  endtask

  // Present vmask, check grant, strobe and response; owner stalls `stall` cycles
  // while every other requester's rsp_ready is high.
  task automatic run_txn(input logic [NREQ-1:0] vmask, input int stall);
    int w;
    logic [DW-1:0] exp_d;
    pack_req();
    req_valid = vmask;
    rsp_ready = '0;
    w = pick(vmask);
    #1;
    chk("grant", 32'(req_ready), 32'(onehot(w)));
    obs_w = decode(req_ready);
    acc_prev = acc_cyc;
    acc_cyc = cyc;
    if (w < 0) begin
      @(negedge clk);
      return;
    end
    if (LOCK_EN && t_lock[w]) begin
      m_lk = 1'b1; m_lk_own = w;
    end else begin
      m_lk = 1'b0; m_rr = (w + 1) % NREQ;
    end
    exp_d = t_wr[w] ? '0 : shadow[t_addr[w]];
    if (t_wr[w]) shadow[t_addr[w]] = t_data[w];
    @(negedge clk); #1;
    chk("reg_we", 32'(reg_we), 32'(t_wr[w]));
    chk("reg_re", 32'(reg_re), 32'(!t_wr[w]));
    chk("ready_busy", 32'(req_ready), 32'(0));
    chk("rsp_early", 32'(rsp_valid), 32'(0));
    if (t_wr[w]) begin
      chk("reg_waddr", 32'(reg_waddr), 32'(t_addr[w]));
      chk("reg_wdata", 32'(reg_wdata), 32'(t_data[w]));
    end else begin
      chk("reg_raddr", 32'(reg_raddr), 32'(t_addr[w]));
    end
    @(negedge clk);
    for (int s = 0; s <= stall; s++) begin
      rsp_ready = (s == stall) ? onehot(w) : ~onehot(w);
      #1;
      chk("rsp_valid", 32'(rsp_valid), 32'(onehot(w)));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_d));
      chk("strobe_off", 32'({reg_we, reg_re}), 32'(0));
      chk("ready_resp", 32'(req_ready), 32'(0));
      @(negedge clk);
    end
    rsp_ready = '0;
    #1;
    chk("rsp_done", 32'(rsp_valid), 32'(0));
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = '0; rsp_ready = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1; m_rr = 0; m_lk = 1'b0; m_lk_own = 0;
  endtask

  initial begin
    logic [NREQ-1:0] v;
    rst = 1'b0; req_valid = '0; rsp_ready = '0; req_write = '0; req_addr = '0; req_wdata = '0;
`ifdef RDL_REG_ARB_LOCK_EN
    req_lock = '0;
`endif
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    m_rr = 0; m_lk = 1'b0; m_lk_own = 0; acc_cyc = 0; acc_prev = 0; obs_w = -1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, '0, '0, 1'b0);

    // Preload the register block and its shadow while reset is held.
    for (int a = 0; a < 2**AW; a++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_a = AW'(a);
      pre_d  = (a == 'h10) ? 8'h3C : DW'($urandom);
      shadow[a] = pre_d;
    end
    @(negedge clk);
    pre_we = 1'b0;

    // Reset: grant forced low even with requests pending.
    req_valid = '1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("rst_strobes", 32'({reg_we, reg_re}), 32'(0));
    chk("rst_addrs", 32'({reg_waddr, reg_raddr, reg_wdata}), 32'(0));
    chk("rst_rsp", 32'({rsp_valid, rsp_rdata}), 32'(0));
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("idle_ready", 32'(req_ready), 32'(0));
    chk("idle_rsp", 32'(rsp_valid), 32'(0));

    // Write from req0, then read from req1 held through 4 stall cycles.
    set_req(0, 1'b1, 6'h05, 8'hA5, 1'b0);
    run_txn(2'b01, 0);
    set_req(1, 1'b0, 6'h10, 8'h00, 1'b0);
    run_txn(2'b10, 4);
    chk("waddr_hold", 32'(reg_waddr), 32'h05);
    chk("wdata_hold", 32'(reg_wdata), 32'hA5);

    // Both requesters valid: strict alternation at a 3-cycle cadence.
    for (int k = 0; k < 6; k++) begin
      set_req(0, 1'($urandom), AW'($urandom), DW'($urandom), 1'b0);
      set_req(1, 1'($urandom), AW'($urandom), DW'($urandom), 1'b0);
      run_txn(2'b11, 0);
      chk("rr_order", 32'(obs_w), 32'(k % 2));
      if (k > 0) chk("cadence", 32'(acc_cyc - acc_prev), 32'd3);
    end

    // Reset during the access cycle of a read.
    set_req(0, 1'b0, 6'h10, 8'h00, 1'b0);
    pack_req();
    req_valid = 2'b01;
    #1;
    chk("mid_grant", 32'(req_ready), 32'h1);
    @(negedge clk); #1;
    chk("mid_re", 32'(reg_re), 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_re_drop", 32'({reg_we, reg_re}), 32'(0));
    chk("mid_rsp", 32'(rsp_valid), 32'(0));
    req_valid = '0; m_rr = 0; m_lk = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("mid_no_rsp", 32'(rsp_valid), 32'(0));
    set_req(1, 1'b0, 6'h10, 8'h00, 1'b0);
    run_txn(2'b11, 0);
    chk("post_rst_gnt", 32'(obs_w), 32'(0));

    // Lock sequence: req0 lock=1,1,0 with req1 always valid.
    do_reset();
    if (LOCK_EN) begin
      exp_lock[0] = 0; exp_lock[1] = 0; exp_lock[2] = 0; exp_lock[3] = 1;
    end else begin
      exp_lock[0] = 0; exp_lock[1] = 1; exp_lock[2] = 0; exp_lock[3] = 1;
    end
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, AW'(k), DW'($urandom), (k < 2) ? 1'b1 : 1'b0);
      set_req(1, 1'b0, AW'($urandom), '0, 1'b0);
      run_txn(2'b11, 0);
      chk("lock_order", 32'(obs_w), 32'(exp_lock[k]));
    end

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      v = NREQ'($urandom);
      if (v == '0) v = onehot($urandom_range(NREQ-1));
      if (LOCK_EN && m_lk) v |= onehot(m_lk_own);
      for (int i = 0; i < NREQ; i++)
        set_req(i, 1'($urandom), AW'($urandom), DW'($urandom), ($urandom_range(3) == 0));
      run_txn(v, $urandom_range(3));
    end

    req_valid = '0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
